// File: rtl/stage_sequencer_pkg.sv
// Shared stage codes (seen by control_unit) and the sequencer's internal state encodings.
package stage_sequencer_pkg;

  typedef enum logic [1:0] {
    STG_LOAD    = 2'b00,
    STG_FETCH   = 2'b01,
    STG_DECODE  = 2'b10,
    STG_EXECUTE = 2'b11
  } stage_t;

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } seq_state_t;

  // HALT presents FETCH so control_unit sees a benign stage while the datapath is frozen.
  function automatic stage_t stage_of(seq_state_t s);
    case (s)
      S_FETCH:  return STG_FETCH;
      S_DECODE: return STG_DECODE;
      S_EXEC:   return STG_EXECUTE;
      S_HALT:   return STG_FETCH;
      default:  return STG_LOAD;
    endcase
  endfunction

endpackage

// File: rtl/stage_sequencer_if.sv
// Boot stream, debug controls and stage/enable outputs of the instruction sequencer.
interface stage_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
);
  logic              ld_valid;
  logic              ld_last;
  logic              ld_ready;
  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic              halt_req;
  logic              step;
  logic              reload;
  logic [1:0]        stage;
  logic              cpu_en;
  logic              pc_clr;
  logic              halted;
  logic              instr_retired;
  logic [CNT_W-1:0]  instr_count;

  modport master (
    output ld_valid, ld_last, halt_req, step, reload,
    input  ld_ready, load_we, load_addr, stage, cpu_en, pc_clr, halted,
           instr_retired, instr_count
  );

  modport slave (
    input  ld_valid, ld_last, halt_req, step, reload,
    output ld_ready, load_we, load_addr, stage, cpu_en, pc_clr, halted,
           instr_retired, instr_count
  );
endinterface

// File: rtl/stage_sequencer_prog_loader.sv
// Boot-stream handshake and program-memory write address; flags the last accepted word.
module stage_sequencer_prog_loader #(
  parameter int PMEM_DEPTH = 256,
  parameter int ADDR_W     = $clog2(PMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              active,
  input  logic              clear,
  input  logic              ld_valid,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              load_we,
  output logic              load_done,
  output logic [ADDR_W-1:0] load_addr
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PMEM_DEPTH - 1);

  assign ld_ready  = active;
  assign load_we   = ld_valid & active;
  // The top word ends the load even without ld_last, so the address never wraps onto word 0.
  assign load_done = load_we & (ld_last | (load_addr == LAST_ADDR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_addr <= '0;
    end else if (clear || load_done) begin
      load_addr <= '0;
    end else if (load_we) begin
      load_addr <= load_addr + 1'b1;
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Instruction sequencer: boot load, then FETCH/DECODE/EXECUTE with halt, single-step and reload.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int PMEM_DEPTH = 256,
  parameter int ADDR_W     = $clog2(PMEM_DEPTH),
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  stage_sequencer_if.slave bus
);
  seq_state_t       state;
  logic             step_pend;
  logic             pc_clr;
  logic [CNT_W-1:0] instr_count;
  logic             load_we;
  logic             load_done;
  logic             ld_ready;
  logic [ADDR_W-1:0] load_addr;

  stage_sequencer_prog_loader #(
    .PMEM_DEPTH (PMEM_DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_loader (
    .clk       (clk),
    .rst_n     (rst_n),
    .active    (state == S_LOAD),
    .clear     ((state == S_HALT) && bus.reload),
    .ld_valid  (bus.ld_valid),
    .ld_last   (bus.ld_last),
    .ld_ready  (ld_ready),
    .load_we   (load_we),
    .load_done (load_done),
    .load_addr (load_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_LOAD;
      step_pend   <= 1'b0;
      pc_clr      <= 1'b0;
      instr_count <= '0;
    end else begin
      pc_clr <= 1'b0;
      case (state)
        S_LOAD: begin
          if (load_done) begin
            pc_clr <= 1'b1;
            state  <= bus.halt_req ? S_HALT : S_FETCH;
          end
        end
        S_FETCH:  state <= S_DECODE;
        S_DECODE: state <= S_EXEC;
        S_EXEC: begin
          instr_count <= instr_count + 1'b1;
          step_pend   <= 1'b0;
          state       <= (bus.halt_req || step_pend) ? S_HALT : S_FETCH;
        end
        S_HALT: begin
          // reload beats step, and step beats a still-asserted halt_req.
          if (bus.reload) begin
            state       <= S_LOAD;
            instr_count <= '0;
          end else if (bus.step) begin
            state     <= S_FETCH;
            step_pend <= 1'b1;
          end else if (!bus.halt_req) begin
            state <= S_FETCH;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  assign bus.ld_ready      = ld_ready;
  assign bus.load_we       = load_we;
  assign bus.load_addr     = load_addr;
  assign bus.stage         = stage_of(state);
  assign bus.cpu_en        = (state == S_LOAD) ? load_we :
                             ((state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC));
  assign bus.pc_clr        = pc_clr;
  assign bus.halted        = (state == S_HALT);
  assign bus.instr_retired = (state == S_EXEC);
  assign bus.instr_count   = instr_count;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer with a per-cycle behavioural reference model.
module tb_stage_sequencer;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stage_sequencer_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  stage_sequencer #(
    .PMEM_DEPTH (DEPTH),
    .ADDR_W     (ADDR_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: phase of the machine described by loading / halted / position-in-instruction.
  bit m_loading, m_halted, m_step, m_pcclr;
  int m_pos, m_addr, m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_loading = 1; m_halted = 0; m_step = 0; m_pcclr = 0;
      m_pos = 0; m_addr = 0; m_cnt = 0;
    end else begin
      m_pcclr = 0;
      if (m_loading) begin
        if (bus.ld_valid) begin
          if (bus.ld_last || m_addr == DEPTH - 1) begin
            m_addr = 0; m_pcclr = 1; m_loading = 0;
            m_halted = bus.halt_req; m_pos = 0;
          end else begin
            m_addr++;
          end
        end
      end else if (m_halted) begin
        if (bus.reload) begin
          m_loading = 1; m_halted = 0; m_addr = 0; m_cnt = 0;
        end else if (bus.step) begin
          m_halted = 0; m_pos = 0; m_step = 1;
        end else if (!bus.halt_req) begin
          m_halted = 0; m_pos = 0;
        end
      end else if (m_pos < 2) begin
        m_pos++;
      end else begin
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
        m_halted = bus.halt_req || m_step;
        m_step = 0; m_pos = 0;
      end
    end
  end

  int wq[$];
  int pc_cnt = 0;
  int ret_cnt = 0;

  always @(negedge clk) begin
    int  e_stage;
    bit  running;
    running = !m_loading && !m_halted;
    e_stage = m_loading ? 0 : (m_halted ? 1 : m_pos + 1);
    chk("stage",         bus.stage,         e_stage);
    chk("ld_ready",      bus.ld_ready,      m_loading);
    chk("load_we",       bus.load_we,       m_loading && bus.ld_valid);
    chk("load_addr",     bus.load_addr,     m_addr);
    chk("cpu_en",        bus.cpu_en,        m_loading ? bus.ld_valid : running);
    chk("pc_clr",        bus.pc_clr,        m_pcclr);
    chk("halted",        bus.halted,        m_halted);
    chk("instr_retired", bus.instr_retired, running && m_pos == 2);
    chk("instr_count",   bus.instr_count,   m_cnt);
    if (bus.load_we) wq.push_back(int'(bus.load_addr));
    if (bus.pc_clr) pc_cnt++;
    if (bus.instr_retired) ret_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_stage(input logic [1:0] s, input int max);
    int n = 0;
    while (bus.stage !== s && n < max) begin
      cyc(1);
      n++;
    end
    if (bus.stage !== s) chk("wait_stage_timeout", bus.stage, s);
  endtask

  initial begin
    int c0;
    bus.ld_valid = 0; bus.ld_last = 0; bus.halt_req = 0; bus.step = 0; bus.reload = 0;
    cyc(2);
    rst_n = 1;
    chk("rst_stage",    bus.stage, 0);
    chk("rst_ld_ready", bus.ld_ready, 1);
    chk("rst_cpu_en",   bus.cpu_en, 0);
    chk("rst_halted",   bus.halted, 0);
    chk("rst_count",    bus.instr_count, 0);

    // 4-word boot with ld_last on the final word
    wq.delete(); pc_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      bus.ld_valid = 1; bus.ld_last = (i == 3);
      cyc(1);
    end
    bus.ld_valid = 0; bus.ld_last = 0;
    chk("t1_nwrites", wq.size(), 4);
    for (int i = 0; i < 4 && i < wq.size(); i++) chk("t1_waddr", wq[i], i);
    chk("t1_stage_f", bus.stage, 1);
    chk("t1_pc_clr",  bus.pc_clr, 1);
    cyc(1); chk("t1_stage_d", bus.stage, 2);
    cyc(1); chk("t1_stage_e", bus.stage, 3);
    cyc(1); chk("t1_stage_f2", bus.stage, 1);
    chk("t1_pc_pulses", pc_cnt, 1);

    // step/reload while running are ignored; run 16 more instructions to wrap the counter
    bus.step = 1; bus.reload = 1; cyc(1); bus.step = 0; bus.reload = 0;
    cyc(47);
    chk("wrap_count", bus.instr_count, 1);

    // halt requested during DECODE
    wait_stage(2'd2, 10);
    c0 = int'(bus.instr_count);
    bus.halt_req = 1;
    cyc(1); chk("t3_exec", bus.stage, 3);
    cyc(1);
    chk("t3_halted", bus.halted, 1);
    chk("t3_cpu_en", bus.cpu_en, 0);
    chk("t3_stage",  bus.stage, 1);
    chk("t3_count",  bus.instr_count, (c0 + 1) % 16);

    // single step with halt_req held
    ret_cnt = 0;
    bus.step = 1; cyc(1); bus.step = 0;
    cyc(8);
    chk("t4_retired", ret_cnt, 1);
    chk("t4_halted",  bus.halted, 1);

    // reload and step together: reload wins
    ret_cnt = 0;
    bus.reload = 1; bus.step = 1; cyc(1); bus.reload = 0; bus.step = 0;
    bus.halt_req = 0;
    chk("t5_stage", bus.stage, 0);
    chk("t5_addr",  bus.load_addr, 0);
    chk("t5_count", bus.instr_count, 0);
    cyc(4);
    chk("t5_retired", ret_cnt, 0);

    // 10 beats without ld_last: only 8 accepted
    wq.delete();
    bus.ld_valid = 1; cyc(10); bus.ld_valid = 0;
    chk("t2_nwrites", wq.size(), 8);
    for (int i = 0; i < 8 && i < wq.size(); i++) chk("t2_waddr", wq[i], i);
    chk("t2_ld_ready", bus.ld_ready, 0);
    chk("t2_stage",    bus.stage, 3);

    // async reset mid-EXEC
    cyc(6);
    wait_stage(2'd3, 10);
    chk("t6_pre_count", bus.instr_count, 2);
    #2 rst_n = 0;
    #1;
    chk("t6_stage",  bus.stage, 0);
    chk("t6_count",  bus.instr_count, 0);
    chk("t6_cpu_en", bus.cpu_en, 0);
    @(posedge clk); #1 rst_n = 1;

    // async reset mid-LOAD at address 5
    bus.ld_valid = 1; cyc(5); bus.ld_valid = 0;
    chk("t6_addr5", bus.load_addr, 5);
    #2 rst_n = 0;
    #1;
    chk("t6_addr0",  bus.load_addr, 0);
    chk("t6_stage2", bus.stage, 0);
    chk("t6_ready",  bus.ld_ready, 1);
    @(posedge clk); #1 rst_n = 1;
    cyc(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
